// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: arbitrates N L1 cache ports onto the single L2/pmem port.
// One transaction is in flight at a time. The winner's command is latched in
// IDLE, driven to memory in BUSY, and completed with a one-cycle req_resp
// pulse in RESP.
// Optional build macro: ARB_FIXED_PRIO_EN selects fixed priority (lowest
// port index wins). Without it, arbitration is round-robin.
`timescale 1ns/1ps
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_address,
  input  logic [NUM_PORTS*LINE_W-1:0]   req_wdata,
  input  logic [NUM_PORTS-1:0]          req_read,
  input  logic [NUM_PORTS-1:0]          req_write,
  output logic [LINE_W-1:0]             req_rdata,
  output logic [NUM_PORTS-1:0]          req_resp,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [LINE_W-1:0]             mem_wdata,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic [LINE_W-1:0]             mem_rdata,
  input  logic                          mem_resp
);

  // Pointer width is derived from the port count and is not meant to be
  // overridden.
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  // Registered transaction context.
  logic [PTR_W-1:0]     grant;
  logic [PTR_W-1:0]     rr_ptr;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [LINE_W-1:0]    cmd_wdata;
  logic                 cmd_write;

  // Arbitration results for the current cycle.
  logic [NUM_PORTS-1:0] req_any;
  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     ptr_after;
  int                   scan_idx;
  logic [PTR_W-1:0]     scan_ptr;

  // Winner's command, selected from the flat request buses.
  logic [ADDR_W-1:0]    sel_addr;
  logic [LINE_W-1:0]    sel_wdata;
  logic                 sel_write;

  // FSM side effects.
  logic                 load_cmd;
  logic                 load_rdata;

  // A port is requesting if either strobe is up; write wins when both are set.
  assign req_any = req_read | req_write;

  // Pick the winning port among the active requests.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    scan_ptr = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      // Lowest index first: the I-cache always beats the D-cache.
      scan_idx = k;
`else
      // Start at rr_ptr and wrap explicitly so non-power-of-2 counts work.
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_PORTS) begin
        scan_idx = scan_idx - NUM_PORTS;
      end
`endif
      scan_ptr = PTR_W'(scan_idx);
      if (!found && req_any[scan_ptr]) begin
        winner = scan_ptr;
        found  = 1'b1;
      end
    end
  end

  // Port after the winner, wrapping from the last port back to 0.
  always_comb begin
    ptr_after = '0;
    if (winner != PTR_W'(NUM_PORTS - 1)) begin
      ptr_after = winner + PTR_W'(1);
    end
  end

  // Steer the winner's address, data and direction onto the latch inputs.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_addr  = req_address[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*LINE_W +: LINE_W];
        sel_write = req_write[i];
      end
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and load strobes for the command and read-data registers.
  always_comb begin
    state_next = state;
    load_cmd   = 1'b0;
    load_rdata = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          load_cmd   = 1'b1;
        end
      end
      BUSY: begin
        // mem_resp is only meaningful here; other states ignore it.
        if (mem_resp) begin
          state_next = RESP;
          load_rdata = !cmd_write;
        end
      end
      RESP: begin
        // IDLE always follows, giving the requester a cycle to drop its
        // request after seeing req_resp.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winner's command and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the wide command and read-data registers are reset because their
    // contents drive outputs that must read zero out of reset.
    if (!rst_n) begin
      grant     <= '0;
      rr_ptr    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_write <= 1'b0;
    end else if (load_cmd) begin
      grant     <= winner;
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
      cmd_write <= sel_write;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr    <= ptr_after;
`endif
    end
  end

  // Capture returned read data; writes leave the last read line in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rdata <= '0;
    end else if (load_rdata) begin
      req_rdata <= mem_rdata;
    end
  end

  // Memory-side command is a pure decode of state, so it drops with reset.
  assign mem_read    = (state == BUSY) && !cmd_write;
  assign mem_write   = (state == BUSY) &&  cmd_write;
  assign mem_address = cmd_addr;
  assign mem_wdata   = cmd_wdata;

  // One-hot completion pulse to the granted port during RESP only.
  always_comb begin
    req_resp = '0;
    if (state == RESP) begin
      req_resp = NUM_PORTS'(1) << grant;
    end
  end

endmodule
